// File: rtl/sig_control_param.sv
// sig_control_param: highway/country signal controller with shared dwell timer and max-green timeout
module sig_control_param #(
    parameter int Y_TO_R_DEL      = 3,
    parameter int R_TO_G_DEL      = 2,
    parameter int HWY_MIN_GREEN   = 4,
    parameter int CNTRY_MAX_GREEN = 8,
    parameter int CNT_W           = 4
) (
    input  logic       clock,
    input  logic       clear,
    input  logic       x,
    output logic [1:0] hwy,
    output logic [1:0] cntry,
    output logic [2:0] state,
    output logic       timeout
);
    typedef enum logic [2:0] {
        S0 = 3'd0, S1 = 3'd1, S2 = 3'd2, S3 = 3'd3, S4 = 3'd4, S5 = 3'd5
    } state_t;
    localparam logic [1:0] GREEN  = 2'd0;
    localparam logic [1:0] YELLOW = 2'd1;
    localparam logic [1:0] RED    = 2'd2;
    localparam logic [CNT_W-1:0] Y_END = CNT_W'((Y_TO_R_DEL < 1 ? 1 : Y_TO_R_DEL) - 1);
    localparam logic [CNT_W-1:0] R_END = CNT_W'((R_TO_G_DEL < 1 ? 1 : R_TO_G_DEL) - 1);
    localparam logic [CNT_W-1:0] H_END = CNT_W'((HWY_MIN_GREEN < 1 ? 1 : HWY_MIN_GREEN) - 1);
    localparam logic [CNT_W-1:0] C_END = CNT_W'((CNTRY_MAX_GREEN < 1 ? 1 : CNTRY_MAX_GREEN) - 1);
    state_t st, nxt;
    logic [CNT_W-1:0] tmr;
    logic max_hit;
    always_comb begin
        max_hit = tmr == C_END;
        nxt = st == S0 ? (x && tmr >= H_END ? S1 : S0) :
              st == S1 ? (tmr == Y_END ? S2 : S1) :
              st == S2 ? (tmr == R_END ? S3 : S2) :
              st == S3 ? (!x || max_hit ? S4 : S3) :
              st == S4 ? (tmr == Y_END ? S5 : S4) :
              st == S5 ? (tmr == R_END ? S0 : S5) : S0;
    end
    always_ff @(posedge clock) begin
        if (clear) begin
            st      <= S0;
            tmr     <= '0;
            timeout <= 1'b0;
        end else begin
            st      <= nxt;
            tmr     <= nxt != st ? '0 : tmr == '1 ? tmr : tmr + 1'b1;
            timeout <= st == S3 && x && max_hit;
        end
    end
    always_comb begin
        state = st;
        hwy   = st == S0 ? GREEN : st == S1 ? YELLOW : RED;
        cntry = st == S3 ? GREEN : st == S4 ? YELLOW : RED;
    end
endmodule

// File: tb/tb_sig_control_param.sv
// tb_sig_control_param: vector table, corner sequences and random run against a phase/dwell model
module tb_sig_control_param;
    localparam int YD = 3, RD = 2, HMIN = 4, CMAX = 8;
    logic clock = 1'b0;
    logic clear = 1'b1, x = 1'b0, clear2 = 1'b1;
    logic [1:0] hwy, cntry, hwy2, cntry2;
    logic [2:0] state, state2;
    logic timeout, timeout2;
    int total = 0, bad = 0;
    int m_ph = 0, m_n = 1;
    bit m_to = 0;
    int hwy_of[6]   = '{0, 1, 2, 2, 2, 2};
    int cntry_of[6] = '{2, 2, 2, 0, 1, 2};
    typedef struct {
        logic c;
        logic xv;
        int   st;
        int   hw;
        int   cn;
        int   to;
    } vec_t;
    vec_t tbl[$];

    sig_control_param dut (
        .clock(clock), .clear(clear), .x(x),
        .hwy(hwy), .cntry(cntry), .state(state), .timeout(timeout)
    );
    sig_control_param #(
        .Y_TO_R_DEL(1), .R_TO_G_DEL(1), .HWY_MIN_GREEN(1), .CNTRY_MAX_GREEN(2), .CNT_W(4)
    ) dut2 (
        .clock(clock), .clear(clear2), .x(1'b1),
        .hwy(hwy2), .cntry(cntry2), .state(state2), .timeout(timeout2)
    );

    always #5 clock = ~clock;

    function automatic int dwell(int ph);
        return ph == 0 ? HMIN : ph == 3 ? CMAX : (ph == 1 || ph == 4) ? YD : RD;
    endfunction

    // Model counts cycles spent in the current phase (1 on entry) and leaves once the dwell is met
    task automatic model(input logic c, input logic xv);
        bit lim, ex;
        if (c) begin
            m_ph = 0; m_n = 1; m_to = 0;
        end else begin
            lim  = m_n >= dwell(m_ph);
            ex   = m_ph == 0 ? (xv && lim) : m_ph == 3 ? (!xv || lim) : lim;
            m_to = m_ph == 3 && xv && lim;
            if (ex) begin
                m_ph = (m_ph + 1) % 6; m_n = 1;
            end else m_n++;
        end
    endtask

    task automatic step(input logic c, input logic xv);
        clear = c; x = xv;
        @(posedge clock);
        model(c, xv);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_state"}, int'(state), m_ph);
        chk({tag, "_hwy"}, int'(hwy), hwy_of[m_ph]);
        chk({tag, "_cntry"}, int'(cntry), cntry_of[m_ph]);
        chk({tag, "_timeout"}, int'(timeout), int'(m_to));
    endtask

    task automatic add(input logic c, input logic xv, input int st, input int to, input int n);
        vec_t v;
        v.c = c; v.xv = xv; v.st = st; v.hw = hwy_of[st]; v.cn = cntry_of[st]; v.to = to;
        repeat (n) tbl.push_back(v);
    endtask

    task automatic run_until(input int target, input logic xv, input int maxn);
        for (int i = 0; i < maxn && int'(state) != target; i++) step(1'b0, xv);
        chk("reach", int'(state), target);
    endtask

    initial begin
        int n;
        logic xr;
        int pat[7] = '{0, 1, 2, 3, 3, 4, 5};
        add(1, 0, 0, 0, 2);
        add(0, 1, 0, 0, 3);
        add(0, 1, 1, 0, 3);
        add(0, 1, 2, 0, 2);
        add(0, 1, 3, 0, 8);
        add(0, 1, 4, 1, 1);
        add(0, 1, 4, 0, 2);
        add(0, 1, 5, 0, 2);
        add(0, 1, 0, 0, 4);
        add(0, 1, 1, 0, 1);
        foreach (tbl[i]) begin
            step(tbl[i].c, tbl[i].xv);
            chk("vec_state", int'(state), tbl[i].st);
            chk("vec_hwy", int'(hwy), tbl[i].hw);
            chk("vec_cntry", int'(cntry), tbl[i].cn);
            chk("vec_timeout", int'(timeout), tbl[i].to);
        end

        step(1, 0); step(1, 0);
        for (int i = 0; i < 20; i++) begin
            step(0, 0);
            chk("idle_state", int'(state), 0);
            chk("idle_lamps", {int'(hwy), int'(cntry)} == {32'd0, 32'd2} ? 1 : 0, 1);
            chk("idle_timeout", int'(timeout), 0);
        end
        step(0, 1);
        chk("late_req", int'(state), 1);

        step(1, 0);
        run_until(3, 1, 20);
        step(0, 1);
        chk("early_s3", int'(state), 3);
        step(0, 0);
        chk("early_exit", int'(state), 4);
        chk("early_timeout", int'(timeout), 0);

        for (int t = 3; t <= 5; t++) begin
            step(1, 0);
            step(0, 1);
            run_until(3, 1, 20);
            if (t >= 4) step(0, 0);
            if (t == 5) run_until(5, 0, 10);
            chk("pre_clear", int'(state), t);
            step(1, 1);
            chk("clr_state", int'(state), 0);
            chk("clr_hwy", int'(hwy), 0);
            chk("clr_cntry", int'(cntry), 2);
            chk("clr_timeout", int'(timeout), 0);
            n = 0;
            for (int i = 0; i < 10 && state == 3'd0; i++) begin
                step(0, 1);
                n++;
            end
            chk("clr_min_green", n, 4);
        end

        xr = 1'b0;
        step(1, 0);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) xr = ~xr;
            step($urandom_range(0, 80) == 0, xr);
            chk_model("rnd");
        end

        @(posedge clock); #1;
        clear2 = 1'b0;
        chk("ovr_reset", int'(state2), 0);
        for (int i = 1; i <= 21; i++) begin
            @(posedge clock); #1;
            chk("ovr_state", int'(state2), pat[i % 7]);
            chk("ovr_hwy", int'(hwy2), hwy_of[pat[i % 7]]);
            chk("ovr_cntry", int'(cntry2), cntry_of[pat[i % 7]]);
            chk("ovr_timeout", int'(timeout2), i % 7 == 5 ? 1 : 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
